// File: rtl/reqxbar_fifo_if.sv
// Requester-side and MC-side signals of one requester's FIFO/crossbar steering stage.
// slave is the steering block itself; master is whatever drives requests and grants.
interface reqxbar_fifo_if #(
  parameter int NMC   = 8,
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic           req_push;
  logic           req_last;
  logic           req_ld_st;
  logic [47:0]    req_vadr;
  logic [1:0]     req_size;
  logic [63:0]    req_wrd_rdctl;
  logic           req_idle;
  logic           req_stall;
  logic [CW-1:0]  req_cnt;
  logic [NMC-1:0] mc_grant;
  logic [NMC-1:0] mc_req_;
  logic           mc_req_last;
  logic           mc_req_ld_st;
  logic [47:0]    mc_req_vadr;
  logic [1:0]     mc_req_size;
  logic [63:0]    mc_req_wrd_rdctl;
  logic           alarm_clr;
  logic           r_ovrflow_alarm;
  logic           r_undflow_alarm;

  modport slave (
    input  req_push, req_last, req_ld_st, req_vadr, req_size, req_wrd_rdctl,
    input  mc_grant, alarm_clr,
    output req_idle, req_stall, req_cnt,
    output mc_req_, mc_req_last, mc_req_ld_st, mc_req_vadr, mc_req_size, mc_req_wrd_rdctl,
    output r_ovrflow_alarm, r_undflow_alarm
  );

  modport master (
    output req_push, req_last, req_ld_st, req_vadr, req_size, req_wrd_rdctl,
    output mc_grant, alarm_clr,
    input  req_idle, req_stall, req_cnt,
    input  mc_req_, mc_req_last, mc_req_ld_st, mc_req_vadr, mc_req_size, mc_req_wrd_rdctl,
    input  r_ovrflow_alarm, r_undflow_alarm
  );
endinterface

// File: rtl/reqxbar_fifo.sv
// Request FIFO plus single-entry steering stage: each buffered request is presented
// low-active to exactly one MC arbiter chosen by vadr[SEL_LSB +: log2(NMC)].
module reqxbar_fifo #(
  parameter int NMC     = 8,
  parameter int SEL_LSB = 6,
  parameter int DEPTH   = 32,
  parameter int WMTHLD  = 26
) (
  input  logic          clk167,
  input  logic          reset167,
  reqxbar_fifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(NMC);
  localparam int EW = 116;

  // Entry layout: {last[115], ld_st[114], vadr[113:66], size[65:64], wrd_rdctl[63:0]}
  logic [EW-1:0]  r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_cnt;
  logic [NMC-1:0] r_mc_req_;
  logic           r_last;
  logic           r_ld_st;
  logic [47:0]    r_vadr;
  logic [1:0]     r_size;
  logic [63:0]    r_wrd;
  logic           r_idle;
  logic           r_stall;
  logic           r_ovf;
  logic           r_udf;

  logic           w_full;
  logic           w_empty;
  logic           w_hold;
  logic           w_pop;
  logic           w_push_ok;
  logic           w_ovf_evt;
  logic           w_udf_evt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [EW-1:0]  w_head;
  logic [47:0]    w_head_vadr;
  logic [SW-1:0]  w_sel;

  assign w_full      = (r_cnt == CW'(DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign w_hold      = |(~r_mc_req_ & ~bus.mc_grant);
  assign w_pop       = ~w_empty & ~w_hold;
  assign w_push_ok   = bus.req_push & ~w_full;
  assign w_ovf_evt   = bus.req_push & w_full;
  assign w_udf_evt   = |(bus.mc_grant & r_mc_req_);
  assign w_cnt_nxt   = r_cnt + CW'(w_push_ok) - CW'(w_pop);
  assign w_head      = r_mem[r_rptr];
  assign w_head_vadr = w_head[113:66];
  assign w_sel       = w_head_vadr[SEL_LSB +: SW];

  // Storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk167) begin
    if (!reset167 && w_push_ok)
      r_mem[r_wptr] <= {bus.req_last, bus.req_ld_st, bus.req_vadr,
                        bus.req_size, bus.req_wrd_rdctl};
  end

  always_ff @(posedge clk167) begin
    if (reset167) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_mc_req_ <= '1;
      r_last    <= 1'b0;
      r_ld_st   <= 1'b0;
      r_vadr    <= '0;
      r_size    <= '0;
      r_wrd     <= '0;
      r_idle    <= 1'b1;
      r_stall   <= 1'b0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_cnt <= w_cnt_nxt;

      // A pending, ungranted request freezes the whole stage.
      if (w_pop) begin
        r_mc_req_ <= ~(NMC'(1) << w_sel);
        {r_last, r_ld_st, r_vadr, r_size, r_wrd} <= w_head;
      end else if (!w_hold) begin
        r_mc_req_ <= '1;
      end

      r_stall <= (w_cnt_nxt >= CW'(WMTHLD));
      r_idle  <= (w_cnt_nxt == '0) & ~w_pop & ~w_hold;

      // An event in the same cycle as alarm_clr keeps the alarm set.
      r_ovf <= w_ovf_evt | (r_ovf & ~bus.alarm_clr);
      r_udf <= w_udf_evt | (r_udf & ~bus.alarm_clr);
    end
  end

  assign bus.req_idle         = r_idle;
  assign bus.req_stall        = r_stall;
  assign bus.req_cnt          = r_cnt;
  assign bus.mc_req_          = r_mc_req_;
  assign bus.mc_req_last      = r_last;
  assign bus.mc_req_ld_st     = r_ld_st;
  assign bus.mc_req_vadr      = r_vadr;
  assign bus.mc_req_size      = r_size;
  assign bus.mc_req_wrd_rdctl = r_wrd;
  assign bus.r_ovrflow_alarm  = r_ovf;
  assign bus.r_undflow_alarm  = r_udf;
endmodule
